// File: rtl/perf_multi.sv
// Multi-channel performance monitor: total/active/idle/first-busy cycle counts plus
// per-channel event counts over a start/done window, with snapshot, abort and sticky overflow.
module perf_multi #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned NUM_EVENTS    = 4,
    parameter int unsigned SATURATE      = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_pulse,
    input  logic                                done_pulse,
    input  logic                                abort_pulse,
    input  logic                                snapshot_req,
    input  logic                                busy_signal,
    input  logic [NUM_EVENTS-1:0]               event_in,
    output logic [COUNTER_WIDTH-1:0]            total_cycles_count,
    output logic [COUNTER_WIDTH-1:0]            active_cycles_count,
    output logic [COUNTER_WIDTH-1:0]            idle_cycles_count,
    output logic [COUNTER_WIDTH-1:0]            first_busy_count,
    output logic [NUM_EVENTS*COUNTER_WIDTH-1:0] event_counts,
    output logic [NUM_EVENTS+3:0]               overflow_flags,
    output logic                                measuring,
    output logic                                measurement_done,
    output logic                                snapshot_valid,
    output logic                                aborted
);

    localparam int unsigned W    = COUNTER_WIDTH;
    localparam int unsigned NE   = NUM_EVENTS;
    localparam int unsigned NF   = NUM_EVENTS + 4;
    localparam logic [W-1:0] ONES = '1;

    typedef enum logic {
        S_IDLE,
        S_MEASURING
    } state_t;

    state_t state, state_nxt;

    logic            do_clear, do_count, do_latch;
    logic            done_nxt, snap_nxt, abort_nxt;

    logic [W-1:0]    total_q, active_q, idle_q, fb_q;
    logic [W-1:0]    total_d, active_d, idle_d, fb_d;
    logic [W-1:0]    ev_q [NE];
    logic [W-1:0]    ev_d [NE];
    logic [NF-1:0]   ovf_q, ovf_d, hit;
    logic            seen_busy_q, seen_busy_d;
    logic            fb_inc;

    // One counter step: saturate or wrap when already all-ones.
    function automatic logic [W-1:0] bump(input logic [W-1:0] c, input logic inc);
        if (!inc) begin
            return c;
        end
        if (c == ONES) begin
            return (SATURATE != 0) ? ONES : '0;
        end
        return c + W'(1);
    endfunction

    // Next counter values for the current cycle, also used as the latch source.
    always_comb begin
        hit         = '0;
        fb_inc      = !seen_busy_q && !busy_signal;
        total_d     = bump(total_q, 1'b1);
        active_d    = bump(active_q, busy_signal);
        idle_d      = bump(idle_q, !busy_signal);
        fb_d        = bump(fb_q, fb_inc);
        hit[0]      = (total_q == ONES);
        hit[1]      = busy_signal && (active_q == ONES);
        hit[2]      = !busy_signal && (idle_q == ONES);
        hit[3]      = fb_inc && (fb_q == ONES);
        for (int i = 0; i < int'(NE); i++) begin
            ev_d[i]    = bump(ev_q[i], event_in[i]);
            hit[4 + i] = event_in[i] && (ev_q[i] == ONES);
        end
        ovf_d       = ovf_q | hit;
        seen_busy_d = seen_busy_q | busy_signal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control; abort beats done beats snapshot while measuring.
    always_comb begin
        state_nxt = state;
        do_clear  = 1'b0;
        do_count  = 1'b0;
        do_latch  = 1'b0;
        done_nxt  = 1'b0;
        snap_nxt  = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_pulse) begin
                    do_clear  = 1'b1;
                    state_nxt = S_MEASURING;
                end
            end
            S_MEASURING: begin
                do_count = 1'b1;
                if (abort_pulse) begin
                    abort_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end else if (done_pulse) begin
                    do_latch  = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (snapshot_req) begin
                    do_latch = 1'b1;
                    snap_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Live counters.
    always_ff @(posedge clk) begin
        if (rst || do_clear) begin
            total_q     <= '0;
            active_q    <= '0;
            idle_q      <= '0;
            fb_q        <= '0;
            ovf_q       <= '0;
            seen_busy_q <= 1'b0;
            for (int i = 0; i < int'(NE); i++) begin
                ev_q[i] <= '0;
            end
        end else if (do_count) begin
            total_q     <= total_d;
            active_q    <= active_d;
            idle_q      <= idle_d;
            fb_q        <= fb_d;
            ovf_q       <= ovf_d;
            seen_busy_q <= seen_busy_d;
            for (int i = 0; i < int'(NE); i++) begin
                ev_q[i] <= ev_d[i];
            end
        end
    end

    // Result registers and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_cycles_count  <= '0;
            active_cycles_count <= '0;
            idle_cycles_count   <= '0;
            first_busy_count    <= '0;
            event_counts        <= '0;
            overflow_flags      <= '0;
            measurement_done    <= 1'b0;
            snapshot_valid      <= 1'b0;
            aborted             <= 1'b0;
        end else begin
            measurement_done <= done_nxt;
            snapshot_valid   <= snap_nxt;
            aborted          <= abort_nxt;
            if (do_latch) begin
                total_cycles_count  <= total_d;
                active_cycles_count <= active_d;
                idle_cycles_count   <= idle_d;
                first_busy_count    <= fb_d;
                overflow_flags      <= ovf_d;
                for (int i = 0; i < int'(NE); i++) begin
                    event_counts[i*W +: W] <= ev_d[i];
                end
            end
        end
    end

    assign measuring = (state == S_MEASURING);

endmodule

// File: doc/perf_multi.md
Name: perf_multi

Overview:
- Parametrised multi-channel performance monitor; successor to the single-channel cycle counter.
- Counts total, active and idle cycles for one start/done measurement window, plus NUM_EVENTS independent event counters and a start-to-first-busy latency.
- Supports mid-run snapshots, abort, and saturating or wrapping counters with sticky overflow flags.
- Sits beside the accelerator core in accel_top; all outputs map to read-only CSRs.

Parameters:
- COUNTER_WIDTH, 32: width of every counter and count output (minimum 2).
- NUM_EVENTS, 4: number of event channels (minimum 1).
- SATURATE, 1: 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^COUNTER_WIDTH.

Ports:
- clk  in  1  system clock; single clock domain; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_pulse  in  1  begins a measurement.
- done_pulse  in  1  ends a measurement and latches the results.
- abort_pulse  in  1  ends a measurement without latching.
- snapshot_req  in  1  copies live counts to the outputs without stopping the measurement.
- busy_signal  in  1  high when the core is doing useful work.
- event_in  in  NUM_EVENTS  per-channel event strobes, sampled every cycle.
- total_cycles_count  out  COUNTER_WIDTH  latched total cycles.
- active_cycles_count  out  COUNTER_WIDTH  latched count of cycles with busy_signal high.
- idle_cycles_count  out  COUNTER_WIDTH  latched count of cycles with busy_signal low.
- first_busy_count  out  COUNTER_WIDTH  latched cycles before the first busy cycle.
- event_counts  out  NUM_EVENTS*COUNTER_WIDTH  latched event counts; channel i is in bits [i*W +: W].
- overflow_flags  out  NUM_EVENTS+4  latched sticky overflow flags. Bit order: [0] total, [1] active, [2] idle, [3] first_busy, [4+i] event i.
- measuring  out  1  high while in S_MEASURING.
- measurement_done  out  1  one-cycle pulse when results latch on done.
- snapshot_valid  out  1  one-cycle pulse when results latch on snapshot.
- aborted  out  1  one-cycle pulse on abort.

Behaviour:
- Reset: rst high at a clock edge forces S_IDLE and zeroes every output and every internal counter/flag. This includes reset in mid-measurement; no pulse is generated.
- FSM has two states: S_IDLE and S_MEASURING.
- S_IDLE, start_pulse high: clear all internal counters, overflow flags and the seen_busy flag; enter S_MEASURING. done_pulse, abort_pulse and snapshot_req are ignored in S_IDLE.
- Counting window:
  - The start cycle S is not counted.
  - Every cycle spent in S_MEASURING is counted, including the terminating done cycle D, so total = D - S.
- Each counted cycle:
  - total increments by 1.
  - busy_signal high: active increments; busy_signal low: idle increments.
  - event counter i increments when event_in[i] is high.
  - first_busy increments while seen_busy is 0 and busy_signal is 0. The first busy cycle sets seen_busy, and first_busy stops counting.
  - If busy is never seen, first_busy equals idle.
- Overflow, applied independently per counter:
  - An increment when the counter is all-ones sets that counter's sticky internal overflow bit.
  - SATURATE=1: the counter holds at all-ones.
  - SATURATE=0: the counter wraps to 0.
  - Invariant: active + idle = total whenever no overflow bit is set.
- Latch value: every latch (done or snapshot) loads the outputs with the counter values including the current cycle's increments and overflow updates. Outputs are valid on the edge after the request.
- done_pulse in S_MEASURING: latch, return to S_IDLE, pulse measurement_done for exactly 1 cycle (the cycle after D).
- abort_pulse in S_MEASURING: return to S_IDLE; outputs keep their previous values; aborted pulses for 1 cycle.
- snapshot_req in S_MEASURING (no done or abort in the same cycle): latch, stay in S_MEASURING, pulse snapshot_valid for 1 cycle. Counting continues uninterrupted.
- Priority in S_MEASURING: abort > done > snapshot. start_pulse is ignored in S_MEASURING. Only one of measurement_done, snapshot_valid or aborted pulses per cycle.
- start_pulse with done_pulse in S_IDLE: start wins and done is ignored.
- measuring is registered state: high from cycle S+1 through D, low from D+1.
- Outputs change only on a latch or on reset.

Test Plan:
- Basic window: start at cycle 0, done at cycle 10, busy high in cycles 3-8 -> total=10, active=6, idle=4, first_busy=2; measurement_done high only in cycle 11; measuring high in cycles 1-10.
- Events: event_in[0] high in all counted cycles, event_in[1] high 3 times, others low, window of 10 cycles -> event_counts ch0=10, ch1=3, ch2=ch3=0; overflow_flags=0.
- Overflow (COUNTER_WIDTH=4, window of 20 cycles, busy always high):
  - SATURATE=1 -> total=15, active=15, flags bits 0 and 1 set.
  - SATURATE=0 -> total=4, active=4, same flags.
  - Next run of 5 cycles -> flags cleared, total=5.
- Snapshot: snapshot_req at counted cycle 4 of a 10-cycle window -> outputs total=4 with snapshot_valid pulse, measuring stays high; done -> total=10 with a measurement_done pulse; snapshot+done in the same cycle -> only measurement_done pulses.
- Abort: a completed run with total=10, then a new run aborted after 7 cycles -> aborted pulses once; outputs still total=10; measurement_done never pulses; state returns to S_IDLE.
- Corner cases:
  - rst asserted at counted cycle 5 -> all outputs 0 and measuring low next cycle, no pulses.
  - start+done together in S_IDLE -> enters S_MEASURING, no latch.
  - Busy never high in an 8-cycle run -> first_busy=8, idle=8.
